cond_status_unit: RTL and testbench

//  Status-register bank plus condition evaluator for the EXE stage. Holds NZCV

---
 rtl/cond_status_unit.sv | 150 +++++++++++++++
 tb/tb_cond_status_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cond_status_unit.sv
// Condition/status unit for the EXE stage.
// Holds NZCV flags for NUM_CTX contexts, evaluates ARM condition codes against
// a selected context (with optional same-cycle write forwarding), and keeps a
// saturating per-context count of condition-failed (squashed) evaluations.
module cond_status_unit #(
    parameter int NUM_CTX = 4,
    parameter int CTX_W   = 2,
    parameter bit FWD     = 1'b1,
    parameter bit OUT_REG = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sr_we,
    input  logic [CTX_W-1:0] sr_wsel,
    input  logic [3:0]       sr_in,
    input  logic             ev_vld,
    input  logic [CTX_W-1:0] ev_sel,
    input  logic [3:0]       ev_cond,
    output logic             ev_vld_o,
    output logic             ev_flag,
    output logic [3:0]       sr_out,
    input  logic [CTX_W-1:0] cnt_rsel,
    output logic [CNT_W-1:0] cnt_out,
    input  logic             cnt_clr
);

    // Storage is sized to the full select range; entries at or above NUM_CTX
    // are never written and therefore always read back as zero.
    localparam int DEPTH = 2 ** CTX_W;

    logic [DEPTH-1:0] ctx_ok;
    logic [3:0]       sr_q  [DEPTH];
    logic [CNT_W-1:0] cnt_q [DEPTH];
    logic             wr_ok;
    logic             ev_ok;
    logic [3:0]       ev_flags_d;
    logic             ev_pass_d;
    logic             squash_d;

    for (genvar g = 0; g < DEPTH; g++) begin : g_ctx_ok
        assign ctx_ok[g] = (g < NUM_CTX);
    end

    // ARM condition-code evaluation, flags ordered {N,Z,C,V}.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = !z;
            4'h2:    cond_pass = c;
            4'h3:    cond_pass = !c;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = !n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = !v;
            4'h8:    cond_pass = c && !z;
            4'h9:    cond_pass = !c || z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = !z && (n == v);
            4'hD:    cond_pass = z || (n != v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        sat_inc = (val == {CNT_W{1'b1}}) ? val : val + 1'b1;
    endfunction

    assign wr_ok = sr_we && ctx_ok[sr_wsel];
    assign ev_ok = ctx_ok[ev_sel];

    // Effective flags of the evaluated context, optionally bypassing a write in the same cycle.
    always_comb begin
        ev_flags_d = 4'b0000;
        if (ev_ok) begin
            if (FWD && sr_we && (sr_wsel == ev_sel)) begin
                ev_flags_d = sr_in;
            end else begin
                ev_flags_d = sr_q[ev_sel];
            end
        end
    end

    assign ev_pass_d = cond_pass(ev_cond, ev_flags_d);
    assign squash_d  = ev_vld && ev_ok && !ev_pass_d;

    // Status-register bank: S-bit writebacks to valid contexts only.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                sr_q[i] <= 4'b0000;
            end else if (wr_ok && (sr_wsel == CTX_W'(i))) begin
                sr_q[i] <= sr_in;
            end
        end
    end

    // Squash counters: a clear on the same context beats an increment.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else if (cnt_clr && (cnt_rsel == CTX_W'(i))) begin
                cnt_q[i] <= '0;
            end else if (squash_d && (ev_sel == CTX_W'(i))) begin
                cnt_q[i] <= sat_inc(cnt_q[i]);
            end
        end
    end

    assign cnt_out = cnt_q[cnt_rsel];

    if (OUT_REG) begin : g_out_reg
        logic       vld_q;
        logic       flag_q;
        logic [3:0] sr_out_q;

        // Result register: flag and flags hold while idle; reset drops any result in flight.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q    <= 1'b0;
                flag_q   <= 1'b0;
                sr_out_q <= 4'b0000;
            end else begin
                vld_q <= ev_vld;
                if (ev_vld) begin
                    flag_q   <= ev_pass_d;
                    sr_out_q <= ev_flags_d;
                end
            end
        end

        assign ev_vld_o = vld_q;
        assign ev_flag  = vld_q && flag_q;
        assign sr_out   = sr_out_q;
    end else begin : g_out_comb
        assign ev_vld_o = ev_vld;
        assign ev_flag  = ev_vld && ev_pass_d;
        assign sr_out   = ev_flags_d;
    end

endmodule

// File: tb/tb_cond_status_unit.sv
// Bench for cond_status_unit: a registered/forwarding instance (defaults) and a
// combinational/non-forwarding instance with a 3-bit counter, driven in lockstep.
module tb_cond_status_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        sr_we;
    logic [1:0]  sr_wsel;
    logic [3:0]  sr_in;
    logic        ev_vld;
    logic [1:0]  ev_sel;
    logic [3:0]  ev_cond;
    logic [1:0]  cnt_rsel;
    logic        cnt_clr;

    logic        vld_a, flag_a, vld_b, flag_b;
    logic [3:0]  sr_a, sr_b;
    logic [15:0] cnt_a;
    logic [2:0]  cnt_b;

    int total = 0;
    int bad   = 0;

    logic [3:0]  m_sr    [4];
    int unsigned m_cnt_a [4];
    int unsigned m_cnt_b [4];
    logic [3:0]  mh_sr;
    logic [5:0]  sb_q [$];

    always #5 clk = ~clk;

    cond_status_unit #(.NUM_CTX(4), .CTX_W(2), .FWD(1'b1), .OUT_REG(1'b1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .sr_we(sr_we), .sr_wsel(sr_wsel), .sr_in(sr_in),
        .ev_vld(ev_vld), .ev_sel(ev_sel), .ev_cond(ev_cond),
        .ev_vld_o(vld_a), .ev_flag(flag_a), .sr_out(sr_a),
        .cnt_rsel(cnt_rsel), .cnt_out(cnt_a), .cnt_clr(cnt_clr)
    );

    cond_status_unit #(.NUM_CTX(4), .CTX_W(2), .FWD(1'b0), .OUT_REG(1'b0), .CNT_W(3)) u_b (
        .clk(clk), .rst(rst), .sr_we(sr_we), .sr_wsel(sr_wsel), .sr_in(sr_in),
        .ev_vld(ev_vld), .ev_sel(ev_sel), .ev_cond(ev_cond),
        .ev_vld_o(vld_b), .ev_flag(flag_b), .sr_out(sr_b),
        .cnt_rsel(cnt_rsel), .cnt_out(cnt_b), .cnt_clr(cnt_clr)
    );

    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        case (c)
            4'h0: return f[2];
            4'h1: return !f[2];
            4'h2: return f[1];
            4'h3: return !f[1];
            4'h4: return f[3];
            4'h5: return !f[3];
            4'h6: return f[0];
            4'h7: return !f[0];
            4'h8: return f[1] & !f[2];
            4'h9: return !f[1] | f[2];
            4'hA: return f[3] ~^ f[0];
            4'hB: return f[3] ^ f[0];
            4'hC: return !f[2] & (f[3] ~^ f[0]);
            4'hD: return f[2] | (f[3] ^ f[0]);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; sr_we = 1'b0; sr_wsel = 2'd0; sr_in = 4'd0;
        ev_vld = 1'b0; ev_sel = 2'd0; ev_cond = 4'd0; cnt_clr = 1'b0;
    endtask

    // One clock cycle with the currently driven inputs: check, predict, advance model.
    task automatic cyc();
        logic [3:0] fa, fb;
        logic       pa, pb;
        logic [5:0] e;
        @(negedge clk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("a_vld",  32'(vld_a),  32'(e[5]));
            chk("a_flag", 32'(flag_a), 32'(e[4]));
            chk("a_sr",   32'(sr_a),   32'(e[3:0]));
        end
        fb = m_sr[ev_sel];
        fa = (sr_we && sr_wsel == ev_sel) ? sr_in : fb;
        pa = ref_pass(ev_cond, fa);
        pb = ref_pass(ev_cond, fb);
        chk("b_vld",  32'(vld_b),  32'(ev_vld));
        chk("b_flag", 32'(flag_b), 32'(ev_vld & pb));
        chk("b_sr",   32'(sr_b),   32'(fb));
        chk("a_cnt",  32'(cnt_a),  m_cnt_a[cnt_rsel]);
        chk("b_cnt",  32'(cnt_b),  m_cnt_b[cnt_rsel]);
        if (rst) begin
            e = 6'd0;
            mh_sr = 4'd0;
        end else if (ev_vld) begin
            e = {1'b1, pa, fa};
            mh_sr = fa;
        end else begin
            e = {2'b00, mh_sr};
        end
        sb_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_sr[i] = 4'd0; m_cnt_a[i] = 0; m_cnt_b[i] = 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (cnt_clr && cnt_rsel == 2'(i)) begin
                    m_cnt_a[i] = 0; m_cnt_b[i] = 0;
                end else if (ev_vld && ev_sel == 2'(i)) begin
                    if (!pa && m_cnt_a[i] < 65535) m_cnt_a[i]++;
                    if (!pb && m_cnt_b[i] < 7) m_cnt_b[i]++;
                end
            end
            if (sr_we) m_sr[sr_wsel] = sr_in;
        end
        #1;
    endtask

    initial begin
        idle();
        cnt_rsel = 2'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_sr[i] = 4'd0; m_cnt_a[i] = 0; m_cnt_b[i] = 0;
        end
        mh_sr = 4'd0;
        chk("rst_a_vld",  32'(vld_a),  32'd0);
        chk("rst_a_flag", 32'(flag_a), 32'd0);
        chk("rst_a_sr",   32'(sr_a),   32'd0);
        chk("rst_a_cnt",  32'(cnt_a),  32'd0);

        // NE on freshly reset flags passes
        ev_vld = 1'b1; ev_sel = 2'd0; ev_cond = 4'b0001;
        cyc();

        // Write Z to ctx1 while evaluating EQ on ctx1, then evaluate again
        idle();
        sr_we = 1'b1; sr_wsel = 2'd1; sr_in = 4'b0100;
        ev_vld = 1'b1; ev_sel = 2'd1; ev_cond = 4'b0000;
        cnt_rsel = 2'd1;
        cyc();
        idle();
        ev_vld = 1'b1; ev_sel = 2'd1; ev_cond = 4'b0000;
        cyc();

        // Walk every condition over every flag value on ctx2
        cnt_rsel = 2'd2;
        for (int f = 0; f < 16; f++) begin
            idle();
            sr_we = 1'b1; sr_wsel = 2'd2; sr_in = 4'(f);
            cyc();
            for (int c = 0; c < 16; c++) begin
                idle();
                ev_vld = 1'b1; ev_sel = 2'd2; ev_cond = 4'(c);
                cyc();
            end
        end

        // Saturation: nine NV evals on ctx3, then passing AL evals
        cnt_rsel = 2'd3;
        for (int k = 0; k < 9; k++) begin
            idle();
            ev_vld = 1'b1; ev_sel = 2'd3; ev_cond = 4'hF;
            cyc();
        end
        for (int k = 0; k < 3; k++) begin
            idle();
            ev_vld = 1'b1; ev_sel = 2'd3; ev_cond = 4'hE;
            cyc();
        end

        // Clear and squash on ctx3 in the same cycle, then look at ctx2
        idle();
        cnt_clr = 1'b1; ev_vld = 1'b1; ev_sel = 2'd3; ev_cond = 4'hF;
        cyc();
        idle();
        cyc();
        cnt_rsel = 2'd2;
        cyc();

        // Mixed traffic with simultaneous writes/evals on different contexts
        for (int k = 0; k < 60; k++) begin
            idle();
            sr_we    = 1'($urandom_range(0, 1));
            sr_wsel  = 2'($urandom_range(0, 3));
            sr_in    = 4'($urandom_range(0, 15));
            ev_vld   = 1'($urandom_range(0, 3) != 0);
            ev_sel   = 2'($urandom_range(0, 3));
            ev_cond  = 4'($urandom_range(0, 15));
            cnt_clr  = ($urandom_range(0, 9) == 0);
            cnt_rsel = 2'($urandom_range(0, 3));
            cyc();
        end

        // Reset with a registered result pending
        idle();
        sr_we = 1'b1; sr_wsel = 2'd0; sr_in = 4'b1011;
        ev_vld = 1'b1; ev_sel = 2'd0; ev_cond = 4'hE;
        cyc();
        idle();
        rst = 1'b1; ev_vld = 1'b1; ev_sel = 2'd0; ev_cond = 4'hF;
        cyc();
        idle();
        for (int r = 0; r < 4; r++) begin
            cnt_rsel = 2'(r);
            ev_vld = 1'b1; ev_sel = 2'(r); ev_cond = 4'h0;
            cyc();
        end
        idle();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
